alu16_lookahead: RTL and testbench

//  16-bit registered ALU with 74181 function set and 74182-style carry lookahead.

---
 rtl/alu16_lookahead.sv | 132 +++++++++++++
 tb/tb_alu16_lookahead.sv | 102 ++++++++++
 2 files changed

// File: rtl/alu16_lookahead.sv
// 16-bit registered ALU: four 74181-style 4-bit slices joined by a 74182-style
// carry lookahead unit. Data active-high; carry-in, carry-out and group P/G active-low.

module alu181_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] sel_i,
  input  logic       mode_i,
  input  logic       c_i,
  output logic [3:0] f_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] x, y, c;

  // x is the per-bit propagate and y the generate; y implies x, so x+y+c is a true add
  assign x = a_i | (b_i & {4{sel_i[0]}}) | (~b_i & {4{sel_i[1]}});
  assign y = (a_i & b_i & {4{sel_i[3]}}) | (a_i & ~b_i & {4{sel_i[2]}});

  assign c[0] = c_i;
  assign c[1] = y[0] | (x[0] & c_i);
  assign c[2] = y[1] | (x[1] & y[0]) | (x[1] & x[0] & c_i);
  assign c[3] = y[2] | (x[2] & y[1]) | (x[2] & x[1] & y[0]) | (x[2] & x[1] & x[0] & c_i);

  assign p_o = &x;
  assign g_o = y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]);

  assign f_o = mode_i ? ~(x ^ y) : (x ^ y ^ c);
endmodule

module lcu182 (
  input  logic       c0_i,
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  output logic [3:1] c_o,
  output logic       p_o,
  output logic       g_o
);
  assign c_o[1] = g_i[0] | (p_i[0] & c0_i);
  assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c0_i);
  assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c0_i);
  assign p_o    = &p_i;
  assign g_o    = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
endmodule

module alu16_lookahead (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        Cin_i,
  input  logic        mode_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] result_o,
  output logic        Cout_o,
  output logic        nBo_o,
  output logic        nGo_o
);
  localparam int NUM_SLICES = 4;

  logic [NUM_SLICES-1:0]      sp, sg;
  logic [NUM_SLICES-1:0]      sc;
  logic [NUM_SLICES-1:0][3:0] sf;
  logic                       c0, c16, gp, gg;

  logic [15:0] result_q, result_d;
  logic        cout_q, cout_d, nbo_q, nbo_d, ngo_q, ngo_d;

  assign c0 = ~Cin_i;

  lcu182 u_lcu (
    .c0_i (c0),
    .p_i  (sp),
    .g_i  (sg),
    .c_o  (sc[3:1]),
    .p_o  (gp),
    .g_o  (gg)
  );
  assign sc[0] = c0;

  genvar k;
  generate
    for (k = 0; k < NUM_SLICES; k++) begin : g_slice
      alu181_slice u_slice (
        .a_i    (a_i[4*k +: 4]),
        .b_i    (b_i[4*k +: 4]),
        .sel_i  (sel_i),
        .mode_i (mode_i),
        .c_i    (sc[k]),
        .f_o    (sf[k]),
        .p_o    (sp[k]),
        .g_o    (sg[k])
      );
    end
  endgenerate

  assign c16 = gg | (gp & c0);

  always_comb begin
    result_d = sf;
    cout_d   = 1'b1;
    nbo_d    = 1'b1;
    ngo_d    = 1'b1;
    if (!mode_i) begin
      // subtract reports an active-low borrow, i.e. the raw carry
      cout_d = (sel_i == 4'b0110) ? c16 : ~c16;
      nbo_d  = ~gp;
      ngo_d  = ~gg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 16'h0000;
      cout_q   <= 1'b1;
      nbo_q    <= 1'b1;
      ngo_q    <= 1'b1;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      nbo_q    <= nbo_d;
      ngo_q    <= ngo_d;
    end
  end

  assign result_o = result_q;
  assign Cout_o   = cout_q;
  assign nBo_o    = nbo_q;
  assign nGo_o    = ngo_q;
endmodule

// File: tb/tb_alu16_lookahead.sv
// Directed bench for alu16_lookahead with hand-computed expected values.

module tb_alu16_lookahead;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b, result;
  logic        cin, mode, cout, nbo, ngo;
  logic [3:0]  sel;
  int          checks = 0;
  int          failures = 0;

  alu16_lookahead dut (
    .clk      (clk),
    .rst      (rst),
    .a_i      (a),
    .b_i      (b),
    .Cin_i    (cin),
    .mode_i   (mode),
    .sel_i    (sel),
    .result_o (result),
    .Cout_o   (cout),
    .nBo_o    (nbo),
    .nGo_o    (ngo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // apply operands, clock once, then check result and Cout
  task automatic op(input string tag, input logic m, input logic [3:0] s,
                    input logic [15:0] av, input logic [15:0] bv, input logic c,
                    input logic [15:0] exp_f, input logic exp_co);
    mode = m; sel = s; a = av; b = bv; cin = c;
    @(posedge clk); #1;
    chk({tag, ".f"}, result, exp_f);
    chk({tag, ".co"}, {15'd0, cout}, {15'd0, exp_co});
  endtask

  task automatic pg(input string tag, input logic exp_nbo, input logic exp_ngo);
    chk({tag, ".nbo"}, {15'd0, nbo}, {15'd0, exp_nbo});
    chk({tag, ".ngo"}, {15'd0, ngo}, {15'd0, exp_ngo});
  endtask

  initial begin
    rst = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0; mode = 1'b0; sel = 4'b1001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.f", result, 16'h0000);
    chk("rst.co", {15'd0, cout}, 16'd1);
    pg("rst", 1'b1, 1'b1);
    @(negedge clk); rst = 1'b0;

    // arithmetic
    op("add1", 1'b0, 4'b1001, 16'hCAFE, 16'hBABE, 1'b0, 16'h85BD, 1'b0);
    pg("add1", 1'b1, 1'b0);
    op("add2", 1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0);
    op("add3", 1'b0, 4'b1001, 16'hAAAA, 16'h5555, 1'b1, 16'hFFFF, 1'b1);
    pg("add3", 1'b0, 1'b1);
    op("add4", 1'b0, 4'b1001, 16'hAAAA, 16'h5555, 1'b0, 16'h0000, 1'b0);
    op("add5", 1'b0, 4'b1001, 16'h0FFF, 16'h0001, 1'b1, 16'h1000, 1'b1);
    op("sub1", 1'b0, 4'b0110, 16'hCAFE, 16'hBABE, 1'b0, 16'h1040, 1'b1);
    pg("sub1", 1'b1, 1'b0);
    op("sub2", 1'b0, 4'b0110, 16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b0);
    op("a2x",  1'b0, 4'b1100, 16'hAAAA, 16'h1234, 1'b1, 16'h5554, 1'b0);
    op("aab",  1'b0, 4'b1000, 16'h8001, 16'h7FFF, 1'b1, 16'h8002, 1'b1);
    op("ainc", 1'b0, 4'b0000, 16'h1234, 16'h5678, 1'b0, 16'h1235, 1'b1);
    op("m1",   1'b0, 4'b0011, 16'h1234, 16'h5678, 1'b1, 16'hFFFF, 1'b1);
    op("dec0", 1'b0, 4'b1111, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
    op("dec5", 1'b0, 4'b1111, 16'h0005, 16'h0000, 1'b1, 16'h0004, 1'b0);
    pg("dec5", 1'b0, 1'b0);

    // logic, Cin irrelevant
    op("xor0", 1'b1, 4'b0110, 16'hDEAD, 16'hBEEF, 1'b0, 16'h6042, 1'b1);
    op("xor1", 1'b1, 4'b0110, 16'hDEAD, 16'hBEEF, 1'b1, 16'h6042, 1'b1);
    pg("xor1", 1'b1, 1'b1);
    op("and",  1'b1, 4'b1011, 16'hDEAD, 16'hBEEF, 1'b0, 16'h9EAD, 1'b1);
    op("or",   1'b1, 4'b1110, 16'hC0DE, 16'h00FF, 1'b1, 16'hC0FF, 1'b1);
    op("notb", 1'b1, 4'b0101, 16'h1234, 16'hB0B0, 1'b0, 16'h4F4F, 1'b1);
    op("nota", 1'b1, 4'b0000, 16'h1234, 16'hB0B0, 1'b0, 16'hEDCB, 1'b1);
    op("ffff", 1'b1, 4'b1100, 16'h1234, 16'hB0B0, 1'b0, 16'hFFFF, 1'b1);

    // asynchronous reset mid-cycle, then recovery
    op("pre",  1'b0, 4'b1001, 16'hCAFE, 16'hBABE, 1'b0, 16'h85BD, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst.f", result, 16'h0000);
    chk("arst.co", {15'd0, cout}, 16'd1);
    pg("arst", 1'b1, 1'b1);
    @(negedge clk); rst = 1'b0;
    op("post", 1'b0, 4'b1001, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
